// File: rtl/sipo_out_slot.sv
// One-entry valid/ready holding register for completed words.
// Latency: load visible next cycle; a load into a full, non-draining slot is dropped and pulses ovr.
module sipo_out_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         dout_ready,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  output logic         ovr
);

  logic accept;

  // A draining slot can take the new word in the same cycle.
  assign accept = load && (!dout_valid || dout_ready);
  assign ovr    = load && dout_valid && !dout_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (accept) begin
      dout       <= data;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer: assembles W-bit words from qualified serial bits.
// Latency: word visible the cycle after its Wth bit; full slot drops new words and sets sticky overrun.
module sipo_deser #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sin,
  input  logic                 sin_valid,
  input  logic                 sync,
  output logic [W-1:0]         dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [$clog2(W)-1:0] bit_cnt,
  output logic                 overrun,
  input  logic                 clr_ovr
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-1:0] sr;
  logic [W-1:0] sr_nxt;
  logic         complete;
  logic         ovr_pulse;

  always_comb begin
    sr_nxt = sr;
    if (MSB_FIRST) sr_nxt = {sr[W-2:0], sin};
    else           sr_nxt = {sin, sr[W-1:1]};
  end

  // A sync cycle starts a new word, so it can never complete the old one.
  assign complete = sin_valid && !sync && (bit_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      if (sin_valid) sr <= sr_nxt;
      if (sync)          bit_cnt <= sin_valid ? CW'(1) : '0;
      else if (complete) bit_cnt <= '0;
      else if (sin_valid) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  sipo_out_slot #(.W(W)) u_slot (
    .clk        (clk),
    .reset      (reset),
    .load       (complete),
    .data       (sr_nxt),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .ovr        (ovr_pulse)
  );

  always_ff @(posedge clk) begin
    if (reset)          overrun <= 1'b0;
    else if (ovr_pulse) overrun <= 1'b1;
    else if (clr_ovr)   overrun <= 1'b0;
  end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-in, parallel-out deserializer: the receive end of the team's 8-bit parallel-to-serial shift link. Samples one serial bit per qualified clock, assembles `W`-bit words in a shift register, and presents each completed word on a one-entry valid/ready output slot. Handles frame resynchronisation and backpressure, and flags words lost to overrun.

## Interface
Parameters:
- `W`, 8: word width in bits, ≥2.
- `MSB_FIRST`, 1: 1 means the first received bit lands in `dout[W-1]`; 0 means it lands in `dout[0]`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `sin`  in  1  serial data bit.
- `sin_valid`  in  1  `sin` is sampled this cycle.
- `sync`  in  1  frame restart: discard the partial word.
- `dout`  out  W  assembled word (holding register).
- `dout_valid`  out  1  `dout` holds an unconsumed word.
- `dout_ready`  in  1  consumer accepts `dout` when `dout_valid` is high.
- `bit_cnt`  out  $clog2(W)  bits collected in the current partial word.
- `overrun`  out  1  sticky: a completed word was dropped.
- `clr_ovr`  in  1  clears `overrun`.

## Operation
- Shift register `sr`:
  - When `MSB_FIRST=1`, `sin_valid` does `sr <= {sr[W-2:0], sin}`.
  - When `MSB_FIRST=0`, `sin_valid` does `sr <= {sin, sr[W-1:1]}`.
- `bit_cnt`:
  - Increments on each `sin_valid`.
  - Wraps from W-1 to 0 on word completion.
- Word completion is `sin_valid && bit_cnt==W-1`. The completed word is the shifted value including the current `sin`.
- Slot behaviour on completion:
  - Slot free (`!dout_valid`), or draining this cycle (`dout_valid && dout_ready`): `dout` <= completed word and `dout_valid` <= 1.
  - Slot full and not draining: the word is dropped, `overrun` <= 1, and `dout` is unchanged.
- Handshake:
  - `dout_valid && dout_ready` with no completion: `dout_valid` <= 0.
  - `dout` holds its value while `dout_valid` is high and `dout_ready` is low.
- `sync`:
  - `bit_cnt` <= 0, or <= 1 if `sin_valid` is also high. In that case the current `sin` is bit 0 of the new word.
  - `sync` never produces a completion. A partial word is discarded silently and does not set `overrun`.
  - `sync` has no effect on the output slot.
- `clr_ovr`: `overrun` <= 0, unless an overrun occurs in the same cycle; set wins.
- Reset values:
  - `sr`=0, `bit_cnt`=0, `dout`=0, `dout_valid`=0, `overrun`=0.
  - A reset mid-word discards the partial word.
  - Reset overrides all other inputs.

## Timing
- Latency: the completing `sin_valid` edge updates `dout` and `dout_valid`. The word is visible in the cycle after the Wth sampled bit.
- Throughput: one word per W `sin_valid` cycles. With `dout_ready` tied high, there are no gaps and no overrun.
- Consume and complete in the same cycle: the new word replaces the old one, `dout_valid` stays 1, and there is no overrun.
- `sin_valid` may be gapped arbitrarily. `bit_cnt` and `sr` hold while `sin_valid` is low.
- `dout_ready` is ignored while `dout_valid` is 0.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- No shared package needed. `W` and `MSB_FIRST` stay local parameters.
- Natural sub-module: `sipo_out_slot`, a one-entry valid/ready holding register. It takes `load`/`data` in, and produces `dout`, `dout_valid`, and an overrun pulse.
- The top level holds the shift register, bit counter, sync logic, and sticky overrun.

## Test plan
- **Basic MSB-first:** reset for 1 cycle; `dout_ready`=1; send 1,0,1,1,0,0,1,1 on consecutive `sin_valid` cycles. Required: `dout`=8'hB3 and `dout_valid`=1 for exactly one cycle, one cycle after the 8th bit; `bit_cnt` back to 0.
- **Back-to-back with gaps:** send 0xB3 then 0xCC MSB-first, with `sin_valid` deasserted for 3 cycles mid-word. Required: 0xB3 then 0xCC delivered; `overrun`=0.
- **Backpressure:** `dout_ready`=0; send 0xB3, 0xCC, 0x5A. Required:
  - `dout` holds 0xB3 with `dout_valid`=1.
  - `overrun` rises on completion of 0xCC; 0x5A is also dropped.
  - Asserting `dout_ready` for one cycle clears `dout_valid`.
  - `clr_ovr` clears `overrun`.
- **Sync mid-word:** send 3 bits 1,1,1, then assert `sync` with `sin_valid`=1 and `sin`=1, then 7 more bits of 0xB3. Required: `dout`=8'hB3; the prior partial bits are gone; no `overrun`.
- **Reset mid-word and LSB-first:** with `MSB_FIRST`=0, send 1,1,0,0,1,1,0,1. Required: `dout`=8'hB3. Repeat, asserting `reset` after bit 4. Required: all outputs return to 0; the following full 8-bit word decodes correctly.
